// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage indices, FSM states
// and the per-hazard stall/bubble vectors built from the stage indices.
package pipe_ctrl_pkg;

   localparam int unsigned STG_F = 0;
   localparam int unsigned STG_D = 1;
   localparam int unsigned STG_E = 2;
   localparam int unsigned STG_M = 3;
   localparam int unsigned STG_W = 4;

   localparam int unsigned N_STG = 5;

   // Architectural zero register never creates a dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN        = 1'b0,
      REDIR_WAIT = 1'b1
   } pipe_ctrl_state_t;

   // A wait in stage k holds every stage up to k and drains k+1.
   localparam logic [N_STG-1:0] BUBBLE_DMEM   = N_STG'(1 << STG_W);
   localparam logic [N_STG-1:0] STALL_DMEM    = BUBBLE_DMEM - N_STG'(1);
   localparam logic [N_STG-1:0] BUBBLE_MULDIV = N_STG'(1 << STG_M);
   localparam logic [N_STG-1:0] STALL_MULDIV  = BUBBLE_MULDIV - N_STG'(1);
   localparam logic [N_STG-1:0] BUBBLE_LDUSE  = N_STG'(1 << STG_E);
   localparam logic [N_STG-1:0] STALL_LDUSE   = BUBBLE_LDUSE - N_STG'(1);
   localparam logic [N_STG-1:0] BUBBLE_IMEM   = N_STG'(1 << STG_D);
   localparam logic [N_STG-1:0] STALL_IMEM    = N_STG'(1 << STG_F);
   // A taken branch squashes the two younger instructions in D and E.
   localparam logic [N_STG-1:0] BUBBLE_BR     = N_STG'((1 << STG_D) | (1 << STG_E));

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags a D-stage source that depends on a load in E.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       e_memread_in,
   input  logic [4:0] e_rd_in,
   input  logic [4:0] d_rs1_in,
   input  logic [4:0] d_rs2_in,
   input  logic       d_uses_rs1_in,
   input  logic       d_uses_rs2_in,
   output logic       load_use_out
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit      = d_uses_rs1_in && (d_rs1_in == e_rd_in);
   assign rs2_hit      = d_uses_rs2_in && (d_rs2_in == e_rd_in);
   assign load_use_out = e_memread_in && (e_rd_in != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule : hazard_detect

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised stall/bubble generation, branch
// redirect with deferral while a fetch is outstanding.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stall/redirect
// performance counters; without it both counter ports read 0.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        imem_busy_in,
   input  logic        dmem_busy_in,
   input  logic        muldiv_busy_in,
   input  logic        e_memread_in,
   input  logic [4:0]  e_rd_in,
   input  logic [4:0]  d_rs1_in,
   input  logic [4:0]  d_rs2_in,
   input  logic        d_uses_rs1_in,
   input  logic        d_uses_rs2_in,
   input  logic        br_taken_in,
   input  logic [63:0] br_target_in,
   output logic [4:0]  stall_out,
   output logic [4:0]  bubble_out,
   output logic        redirect_out,
   output logic [63:0] redirect_pc_out,
   output logic [31:0] stall_cnt_out,
   output logic [31:0] redir_cnt_out
);

   pipe_ctrl_state_t state_q, state_d;
   logic [63:0]      pend_pc_q, pend_pc_d;
   logic             load_use;

   hazard_detect u_hazard_detect (
      .e_memread_in  (e_memread_in),
      .e_rd_in       (e_rd_in),
      .d_rs1_in      (d_rs1_in),
      .d_rs2_in      (d_rs2_in),
      .d_uses_rs1_in (d_uses_rs1_in),
      .d_uses_rs2_in (d_uses_rs2_in),
      .load_use_out  (load_use)
   );

   // Priority mux and next-state logic for the redirect FSM.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_d         = state_q;
      pend_pc_d       = pend_pc_q;
      stall_out       = '0;
      bubble_out      = '0;
      redirect_out    = 1'b0;
      redirect_pc_out = '0;

      if (dmem_busy_in) begin
         stall_out  = STALL_DMEM;
         bubble_out = BUBBLE_DMEM;
      end else if (muldiv_busy_in) begin
         stall_out  = STALL_MULDIV;
         bubble_out = BUBBLE_MULDIV;
      end else if (state_q == REDIR_WAIT) begin
         // D and E already hold bubbles here, so neither a load-use nor a
         // new branch can be real; only the outstanding fetch matters.
         if (imem_busy_in) begin
            stall_out  = STALL_IMEM;
            bubble_out = BUBBLE_IMEM;
         end else if (!reset) begin
            redirect_out    = 1'b1;
            redirect_pc_out = pend_pc_q;
            bubble_out      = BUBBLE_IMEM;
            state_d         = RUN;
         end
      end else if (load_use) begin
         stall_out  = STALL_LDUSE;
         bubble_out = BUBBLE_LDUSE;
      end else if (br_taken_in) begin
         bubble_out = BUBBLE_BR;
         if (imem_busy_in) begin
            stall_out = STALL_IMEM;
            pend_pc_d = br_target_in;
            state_d   = REDIR_WAIT;
         end else begin
            redirect_out    = 1'b1;
            redirect_pc_out = br_target_in;
         end
      end else if (imem_busy_in) begin
         stall_out  = STALL_IMEM;
         bubble_out = BUBBLE_IMEM;
      end

      // A back-end wait during REDIR_WAIT keeps squashing D; D already holds
      // a bubble, so reloading zero is the same as holding and keeps stall
      // and bubble disjoint.
      if ((state_q == REDIR_WAIT) && (dmem_busy_in || muldiv_busy_in)) begin
         bubble_out[STG_D] = 1'b1;
         stall_out[STG_D]  = 1'b0;
      end
   end

   // FSM state and pending redirect target.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= RUN;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;

   // Free-running event counters, wrapping at 2^32.
   always_comb begin
      stall_cnt_d = stall_cnt_q + 32'(|stall_out);
      redir_cnt_d = redir_cnt_q + 32'(redirect_out);
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign stall_cnt_out = stall_cnt_q;
   assign redir_cnt_out = redir_cnt_q;
`else
   assign stall_cnt_out = '0;
   assign redir_cnt_out = '0;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios followed by
// random traffic, all compared against a stage-oriented reference model.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_busy_in, dmem_busy_in, muldiv_busy_in;
   logic        e_memread_in;
   logic [4:0]  e_rd_in, d_rs1_in, d_rs2_in;
   logic        d_uses_rs1_in, d_uses_rs2_in;
   logic        br_taken_in;
   logic [63:0] br_target_in;
   logic [4:0]  stall_out, bubble_out;
   logic        redirect_out;
   logic [63:0] redirect_pc_out;
   logic [31:0] stall_cnt_out, redir_cnt_out;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .imem_busy_in    (imem_busy_in),
      .dmem_busy_in    (dmem_busy_in),
      .muldiv_busy_in  (muldiv_busy_in),
      .e_memread_in    (e_memread_in),
      .e_rd_in         (e_rd_in),
      .d_rs1_in        (d_rs1_in),
      .d_rs2_in        (d_rs2_in),
      .d_uses_rs1_in   (d_uses_rs1_in),
      .d_uses_rs2_in   (d_uses_rs2_in),
      .br_taken_in     (br_taken_in),
      .br_target_in    (br_target_in),
      .stall_out       (stall_out),
      .bubble_out      (bubble_out),
      .redirect_out    (redirect_out),
      .redirect_pc_out (redirect_pc_out),
      .stall_cnt_out   (stall_cnt_out),
      .redir_cnt_out   (redir_cnt_out)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state: "waiting" means a taken branch is parked until
   // the outstanding fetch returns.
   bit          m_wait, m_wait_nxt;
   logic [63:0] m_pend, m_pend_nxt;
   logic [31:0] m_scnt, m_rcnt;
   logic [4:0]  exp_stall, exp_bubble;
   logic        exp_redir;
   logic [63:0] exp_pc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: a wait in stage k (F=0 .. M=3) holds stages 0..k and drains k+1.
   task automatic model_eval();
      int   k;
      logic lu;
      lu = e_memread_in && (e_rd_in != 0) &&
           ((d_uses_rs1_in && d_rs1_in == e_rd_in) || (d_uses_rs2_in && d_rs2_in == e_rd_in));
      exp_stall  = '0;
      exp_bubble = '0;
      exp_redir  = 1'b0;
      exp_pc     = '0;
      m_wait_nxt = m_wait;
      m_pend_nxt = m_pend;
      k = -1;
      if (dmem_busy_in)         k = 3;
      else if (muldiv_busy_in)  k = 2;
      else if (!m_wait && lu)   k = 1;
      if (k >= 0) begin
         exp_stall  = 5'((1 << (k + 1)) - 1);
         exp_bubble = 5'(1 << (k + 1));
         if (m_wait) begin
            exp_bubble[1] = 1'b1;
            exp_stall[1]  = 1'b0;
         end
      end else if (m_wait) begin
         if (imem_busy_in) begin
            exp_stall  = 5'b00001;
            exp_bubble = 5'b00010;
         end else if (!reset) begin
            exp_redir  = 1'b1;
            exp_pc     = m_pend;
            exp_bubble = 5'b00010;
            m_wait_nxt = 1'b0;
         end
      end else if (br_taken_in) begin
         exp_bubble = 5'b00110;
         if (imem_busy_in) begin
            exp_stall  = 5'b00001;
            m_wait_nxt = 1'b1;
            m_pend_nxt = br_target_in;
         end else begin
            exp_redir = 1'b1;
            exp_pc    = br_target_in;
         end
      end else if (imem_busy_in) begin
         exp_stall  = 5'b00001;
         exp_bubble = 5'b00010;
      end
   endtask

   task automatic model_clock();
      if (reset) begin
         m_wait = 1'b0;
         m_pend = '0;
         m_scnt = '0;
         m_rcnt = '0;
      end else begin
         m_wait = m_wait_nxt;
         m_pend = m_pend_nxt;
         if (PERF && exp_stall != 0) m_scnt = m_scnt + 1;
         if (PERF && exp_redir)      m_rcnt = m_rcnt + 1;
      end
   endtask

   // Let inputs settle after the falling edge, then compare against the model.
   task automatic settle(input string tag);
      #1;
      model_eval();
      chk({tag, ".stall"},  64'(stall_out),       64'(exp_stall));
      chk({tag, ".bubble"}, 64'(bubble_out),      64'(exp_bubble));
      chk({tag, ".redir"},  64'(redirect_out),    64'(exp_redir));
      chk({tag, ".pc"},     redirect_pc_out,      exp_pc);
      chk({tag, ".scnt"},   64'(stall_cnt_out),   64'(m_scnt));
      chk({tag, ".rcnt"},   64'(redir_cnt_out),   64'(m_rcnt));
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      imem_busy_in   = 1'b0;
      dmem_busy_in   = 1'b0;
      muldiv_busy_in = 1'b0;
      e_memread_in   = 1'b0;
      e_rd_in        = '0;
      d_rs1_in       = '0;
      d_rs2_in       = '0;
      d_uses_rs1_in  = 1'b0;
      d_uses_rs2_in  = 1'b0;
      br_taken_in    = 1'b0;
      br_target_in   = '0;
   endtask

   initial begin
      logic [31:0] scnt_base;
      reset = 1'b1;
      idle_inputs();
      m_wait = 1'b0; m_pend = '0; m_scnt = '0; m_rcnt = '0;
      @(posedge clk);
      @(negedge clk);
      settle("in_reset");
      tick();
      reset = 1'b0;
      settle("post_reset");
      chk("idle_pc_zero", redirect_pc_out, 64'h0);
      tick();

      // Load-use on rs2: one stall cycle, then the bubble has cleared E.
      e_memread_in = 1'b1; e_rd_in = 5'd5; d_rs2_in = 5'd5; d_uses_rs2_in = 1'b1;
      settle("ldu");
      chk("ldu_stall_const",  64'(stall_out),  64'(5'b00011));
      chk("ldu_bubble_const", 64'(bubble_out), 64'(5'b00100));
      tick();
      idle_inputs();
      settle("ldu_after");
      tick();

      // Zero register never stalls.
      e_memread_in = 1'b1; e_rd_in = 5'd0; d_rs1_in = 5'd0; d_uses_rs1_in = 1'b1;
      settle("x0");
      chk("x0_no_stall", 64'(stall_out), 64'h0);
      tick();
      idle_inputs();

      // Branch in RUN with idle fetch: immediate redirect.
      br_taken_in = 1'b1; br_target_in = 64'h8000_0040;
      settle("br_run");
      chk("br_run_redir", 64'(redirect_out), 64'h1);
      chk("br_run_pc",    redirect_pc_out,   64'h8000_0040);
      chk("br_run_bub",   64'(bubble_out),   64'(5'b00110));
      tick();
      idle_inputs();

      // Branch while a fetch is outstanding for 3 cycles.
      imem_busy_in = 1'b1; br_taken_in = 1'b1; br_target_in = 64'h100;
      settle("brw_c0");
      tick();
      br_target_in = 64'hdead_beef;  // further branches ignored while waiting
      for (int c = 1; c < 3; c++) begin
         settle($sformatf("brw_c%0d", c));
         chk($sformatf("brw_c%0d_noredir", c), 64'(redirect_out), 64'h0);
         tick();
      end
      imem_busy_in = 1'b0; br_taken_in = 1'b0;
      settle("brw_c3");
      chk("brw_c3_redir", 64'(redirect_out), 64'h1);
      chk("brw_c3_pc",    redirect_pc_out,   64'h100);
      tick();
      idle_inputs();
      settle("brw_c4_run");
      tick();

      // dmem wait over a muldiv wait and a load-use.
      scnt_base = m_scnt;
      dmem_busy_in = 1'b1; muldiv_busy_in = 1'b1;
      e_memread_in = 1'b1; e_rd_in = 5'd7; d_rs1_in = 5'd7; d_uses_rs1_in = 1'b1;
      for (int c = 0; c < 4; c++) begin
         settle($sformatf("dmem_c%0d", c));
         chk($sformatf("dmem_c%0d_stall", c), 64'(stall_out),  64'(5'b01111));
         chk($sformatf("dmem_c%0d_bub", c),   64'(bubble_out), 64'(5'b10000));
         tick();
      end
      idle_inputs();
      settle("dmem_after");
      chk("dmem_cnt_delta", 64'(stall_cnt_out), 64'(scnt_base + (PERF ? 32'd4 : 32'd0)));
      tick();

      // Reset while waiting for a parked redirect.
      imem_busy_in = 1'b1; br_taken_in = 1'b1; br_target_in = 64'h2000;
      settle("rstw_enter");
      tick();
      idle_inputs();
      reset = 1'b1;
      settle("rstw_in_reset");
      chk("rstw_no_redir", 64'(redirect_out), 64'h0);
      tick();
      reset = 1'b0;
      settle("rstw_after");
      chk("rstw_after_redir", 64'(redirect_out), 64'h0);
      chk("rstw_after_scnt",  64'(stall_cnt_out), 64'h0);
      chk("rstw_after_rcnt",  64'(redir_cnt_out), 64'h0);
      tick();

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         reset          = ($urandom_range(0, 99) < 3);
         imem_busy_in   = $urandom_range(0, 1);
         dmem_busy_in   = ($urandom_range(0, 99) < 15);
         muldiv_busy_in = ($urandom_range(0, 99) < 15);
         e_memread_in   = m_wait ? 1'b0 : 1'($urandom_range(0, 1));
         e_rd_in        = 5'($urandom_range(0, 3));
         d_rs1_in       = 5'($urandom_range(0, 3));
         d_rs2_in       = 5'($urandom_range(0, 3));
         d_uses_rs1_in  = $urandom_range(0, 1);
         d_uses_rs2_in  = $urandom_range(0, 1);
         br_taken_in    = ($urandom_range(0, 99) < 25);
         br_target_in   = {$urandom, $urandom};
         settle($sformatf("rnd%0d", n));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- imem_busy_in  input  1  fetch access outstanding.
- dmem_busy_in  input  1  data access in M outstanding.
- muldiv_busy_in  input  1  multi-cycle ALU op in E not done.
- e_memread_in  input  1  instruction in E is a load.
- e_rd_in  input  5  destination of E.
- d_rs1_in, d_rs2_in  input  5 each  sources of D.
- d_uses_rs1_in, d_uses_rs2_in  input  1 each  D reads rs1/rs2.
- br_taken_in  input  1  E resolved a taken branch or jump.
- br_target_in  input  64  redirect PC from E.
- stall_out  output  5  hold per stage register: [0]=F/PC, [1]=D, [2]=E, [3]=M, [4]=W.
- bubble_out  output  5  load all-zero into that stage register, same bit order.
- redirect_out  output  1  F loads redirect_pc_out this cycle.
- redirect_pc_out  output  64  redirect target.
- stall_cnt_out  output  32  cycles with any stall_out bit set.
- redir_cnt_out  output  32  redirects issued.

Function
REQ-002 stall_out, bubble_out and redirect_out SHALL be combinational from current inputs and registered state (zero-cycle latency).
REQ-003 Hazard priority, highest first: dmem wait, muldiv wait, load-use, redirect, imem wait.
REQ-004 dmem_busy_in=1 SHALL give stall_out=5'b01111 and bubble_out=5'b10000, so W writes back nothing while blocked.
REQ-005 Else muldiv_busy_in=1 SHALL give stall_out=5'b00111 and bubble_out=5'b01000.
REQ-006 Else load-use SHALL give stall_out=5'b00011 and bubble_out=5'b00100. Load-use = e_memread_in & e_rd_in!=0 & ((d_uses_rs1_in & d_rs1_in==e_rd_in) | (d_uses_rs2_in & d_rs2_in==e_rd_in)).
REQ-007 Load-use SHALL last exactly one cycle per load, because the bubble clears E.
REQ-008 Else br_taken_in=1 with imem_busy_in=0 (state RUN) SHALL give redirect_out=1, redirect_pc_out=br_target_in, bubble_out=5'b00110 and stall_out=0.
REQ-009 Else br_taken_in=1 with imem_busy_in=1 SHALL:
- latch br_target_in into pend_pc;
- go to state REDIR_WAIT;
- give bubble_out=5'b00110 and stall_out=5'b00001.
REQ-010 In REDIR_WAIT, while imem_busy_in=1, the block SHALL give stall_out=5'b00001 and bubble_out=5'b00010, and SHALL ignore further br_taken_in.
REQ-011 In REDIR_WAIT, on the first cycle with imem_busy_in=0, the block SHALL:
- give redirect_out=1, redirect_pc_out=pend_pc, bubble_out=5'b00010;
- return to RUN (the wrong-path fetch is discarded).
REQ-012 Else imem_busy_in=1 in RUN SHALL give stall_out=5'b00001 and bubble_out=5'b00010.
REQ-013 A higher-priority dmem or muldiv wait during REDIR_WAIT SHALL apply its own vectors, OR bubble_out[1] into them, hold the state, and hold pend_pc.
REQ-014 No bit SHALL be set in both stall_out and bubble_out in the same cycle.
REQ-015 With no hazard, all outputs SHALL be 0 and redirect_pc_out SHALL be 0.

Reset
REQ-016 On reset the block SHALL set state=RUN, pend_pc=0 and both counters=0. Combinational outputs follow from that state.
REQ-017 Reset asserted in REDIR_WAIT SHALL drop the pending redirect without emitting redirect_out.

Configuration
REQ-018 With PIPE_CTRL_PERF_EN defined:
- stall_cnt_out SHALL increment on every cycle with stall_out!=0;
- redir_cnt_out SHALL increment on every cycle with redirect_out=1;
- both SHALL wrap modulo 2^32.
REQ-019 Without PIPE_CTRL_PERF_EN, both ports SHALL remain present and tied to 0, with no counter flops.

Structure
REQ-020 The stage index constants (STG_F=0 through STG_W=4) and the pipe_ctrl_state_t enum {RUN, REDIR_WAIT} SHALL be defined in the shared common package.
REQ-021 The load-use comparator SHALL be the sub-module hazard_detect (purely combinational). The FSM and priority mux stay in pipe_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load-use: e_memread_in=1, e_rd_in=5, d_rs2_in=5, d_uses_rs2_in=1 -> one cycle of stall_out=00011, bubble_out=00100.
- Zero register: e_rd_in=0 with a matching rs1 -> no stall.
- Branch in RUN: br_taken_in=1, br_target_in=0x8000_0040, imem idle -> redirect_out=1 with that PC and bubble_out=00110 in the same cycle.
- Branch during fetch: imem_busy_in high for 3 cycles, br_taken_in pulse in cycle 0 with target 0x100 -> REDIR_WAIT for 3 cycles, then redirect_out=1 with PC 0x100 in cycle 3, then RUN.
- dmem_busy_in for 4 cycles during a muldiv wait and a load-use -> stall_out=01111 and bubble_out=10000 each cycle. With PIPE_CTRL_PERF_EN, stall_cnt_out increases by 4.
- reset asserted in REDIR_WAIT -> state RUN, no redirect_out, counters 0 on the next cycle.
